// File: rtl/afifo_pattern_pkg.sv
// Shared definitions for the async FIFO pattern checker: FSM states and the
// test-pattern definition used by both the read-side checker and the
// write-side generator.
package afifo_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } afifo_state_t;

  localparam logic [19:0]  PATTERN_CONST = 20'h55000;
  localparam int unsigned  PATTERN_SHIFT = 20;

  // Expected FIFO word for a given index, masked to the FIFO data width.
  function automatic logic [31:0] afifo_expected(input logic [31:0] index,
                                                 input int unsigned width);
    logic [31:0] raw;
    logic [31:0] mask;
    raw  = index | (index << PATTERN_SHIFT) | {12'h000, PATTERN_CONST};
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return raw & mask;
  endfunction

endpackage

// File: rtl/afifo_pattern_gen.sv
// Combinational expected-word generator. Kept as its own block so the read
// checker and the write-side generator share one pattern definition.
module afifo_pattern_gen
  import afifo_pattern_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned INDEX_WIDTH = 10
) (
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0]  expected
);

  // Pattern word for the requested index
  always_comb begin
    expected = DATA_WIDTH'(afifo_expected(32'(index), DATA_WIDTH));
  end

endmodule

// File: rtl/afifo_pattern_reader.sv
// Read-side traffic checker for the BRAM async FIFO: pops DEPTH words,
// compares each against the shared pattern and reports errors, underruns
// and completion.
module afifo_pattern_reader
  import afifo_pattern_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock0,
  input  logic                  Async_Flush,
  input  logic                  Start,
  input  logic                  Empty,
  input  logic                  Underrun_Error,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  POP,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Mismatch,
  output logic [CNT_WIDTH-1:0]  Error_Count,
  output logic [ADDR_WIDTH-1:0] Fail_Index
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  afifo_state_t          state;
  logic [ADDR_WIDTH:0]   pops_issued;
  logic [ADDR_WIDTH:0]   pops_next;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_index [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] check_index;
  logic                  check_valid;
  logic                  check_fail;
  logic                  pipe_drains;
  logic [DATA_WIDTH-1:0] expected;

  afifo_pattern_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (ADDR_WIDTH)
  ) u_gen (
    .index    (check_index),
    .expected (expected)
  );

  // Pop accounting, pipe-output compare and drain detection
  always_comb begin
    pops_next   = pops_issued + {{ADDR_WIDTH{1'b0}}, POP};
    check_valid = pipe_valid[RD_LATENCY-1];
    check_index = pipe_index[RD_LATENCY-1];
    check_fail  = check_valid && (DOUT != expected);
    // The pipe is empty after this edge when only the output stage (if any) holds a word.
    pipe_drains = 1'b1;
    for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
      if (pipe_valid[i]) pipe_drains = 1'b0;
    end
  end

  // Read-latency pipe carrying {valid,index} of each accepted pop to the compare point
  always_ff @(posedge clock0 or posedge Async_Flush) begin
    if (Async_Flush) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_index[i] <= '0;
    end else begin
      pipe_valid[0] <= POP;
      pipe_index[0] <= pops_issued[ADDR_WIDTH-1:0];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_index[i] <= pipe_index[i-1];
      end
    end
  end

  // Pass FSM with registered POP/Busy/Done and error bookkeeping
  always_ff @(posedge clock0 or posedge Async_Flush) begin
    if (Async_Flush) begin
      state       <= ST_IDLE;
      POP         <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Mismatch    <= 1'b0;
      Error_Count <= '0;
      Fail_Index  <= '0;
      pops_issued <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state       <= ST_READ;
            Busy        <= 1'b1;
            Done        <= 1'b0;
            Mismatch    <= 1'b0;
            Error_Count <= '0;
            Fail_Index  <= '0;
            pops_issued <= '0;
            POP         <= ~Empty;
          end
        end
        ST_READ: begin
          pops_issued <= pops_next;
          if (pops_next == DEPTH) begin
            state <= ST_DRAIN;
            POP   <= 1'b0;
          end else begin
            POP <= ~Empty;
          end
        end
        ST_DRAIN: begin
          if (pipe_drains) begin
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (check_fail) begin
        Mismatch <= 1'b1;
        if (Error_Count == '0) Fail_Index <= check_index;
        if (Error_Count != '1) Error_Count <= Error_Count + CNT_WIDTH'(1);
      end

      if (Busy && Underrun_Error) Mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_afifo_pattern_reader.sv
// Bench for afifo_pattern_reader: behavioural FIFOs feed two configurations;
// a queue-based pass model checks the 18-bit/1024-word instance every cycle,
// the 9-bit/2048-word latency-2 instance is checked per pass.
module tb_afifo_pattern_reader;

  localparam int unsigned A_DEPTH = 1024;
  localparam int unsigned A_LAT   = 1;
  localparam int unsigned A_CMAX  = 65535;
  localparam int unsigned B_DEPTH = 2048;

  logic        clk;
  logic        a_flush, a_start, a_empty, a_under;
  logic [17:0] a_dout;
  logic        a_pop, a_busy, a_done, a_mis;
  logic [15:0] a_cnt;
  logic [9:0]  a_fidx;

  logic        b_flush, b_start, b_empty, b_under;
  logic [8:0]  b_dout;
  logic        b_pop, b_busy, b_done, b_mis;
  logic [3:0]  b_cnt;
  logic [10:0] b_fidx;

  afifo_pattern_reader #(
    .DATA_WIDTH (18), .ADDR_WIDTH (10), .RD_LATENCY (1), .CNT_WIDTH (16)
  ) dut_a (
    .clock0 (clk), .Async_Flush (a_flush), .Start (a_start), .Empty (a_empty),
    .Underrun_Error (a_under), .DOUT (a_dout), .POP (a_pop), .Busy (a_busy),
    .Done (a_done), .Mismatch (a_mis), .Error_Count (a_cnt), .Fail_Index (a_fidx)
  );

  afifo_pattern_reader #(
    .DATA_WIDTH (9), .ADDR_WIDTH (11), .RD_LATENCY (2), .CNT_WIDTH (4)
  ) dut_b (
    .clock0 (clk), .Async_Flush (b_flush), .Start (b_start), .Empty (b_empty),
    .Underrun_Error (b_under), .DOUT (b_dout), .POP (b_pop), .Busy (b_busy),
    .Done (b_done), .Mismatch (b_mis), .Error_Count (b_cnt), .Fail_Index (b_fidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total, bad;

  // behavioural FIFO contents and read state
  logic [17:0] mem_a [A_DEPTH];
  logic [8:0]  mem_b [B_DEPTH];
  int unsigned rp_a, rp_b, a_pops_seen, b_pops_seen;
  logic [8:0]  b_dq0, b_dq1;
  bit          last_a_empty, last_b_empty;

  // pass model for instance A
  int unsigned m_t, m_pops, m_checked, m_cnt, m_fidx;
  bit          m_active, m_done, m_mis, m_pop;
  int unsigned due_q[$];
  int unsigned idx_q[$];

  function automatic longint unsigned pat(input longint unsigned i, input int unsigned w);
    longint unsigned v;
    v = i | (i << 20) | 64'h55000;
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pops = 0; m_checked = 0; m_cnt = 0; m_fidx = 0;
    m_active = 0; m_done = 0; m_mis = 0; m_pop = 0;
    due_q.delete(); idx_q.delete();
  endtask

  // Advance the pass model across one rising edge with the given inputs.
  task automatic model_edge(input bit st, input bit em, input bit ur);
    int unsigned idx;
    bit was_active;
    was_active = m_active;
    m_t++;
    if (due_q.size() > 0 && due_q[0] == m_t) begin
      void'(due_q.pop_front());
      idx = idx_q.pop_front();
      m_checked++;
      if (longint'(mem_a[idx]) != pat(idx, 18)) begin
        if (m_cnt == 0) m_fidx = idx;
        if (m_cnt < A_CMAX) m_cnt++;
        m_mis = 1;
      end
      if (m_checked == A_DEPTH) begin
        m_done = 1;
        m_active = 0;
      end
    end
    if (was_active && ur) m_mis = 1;
    if (m_pop) begin
      due_q.push_back(m_t + A_LAT);
      idx_q.push_back(m_pops);
      m_pops++;
    end
    if (!was_active && st) begin
      m_active = 1; m_done = 0; m_mis = 0; m_cnt = 0; m_fidx = 0;
      m_pops = 0; m_checked = 0;
    end
    m_pop = m_active && (m_pops < A_DEPTH) && !em;
  endtask

  task automatic check_a();
    chk("a_pop", a_pop, m_pop);
    chk("a_busy", a_busy, m_active);
    chk("a_done", a_done, m_done);
    chk("a_mismatch", a_mis, m_mis);
    chk("a_error_count", a_cnt, m_cnt);
    chk("a_fail_index", a_fidx, m_fidx);
  endtask

  // One clock: check at the falling edge, drive inputs, then let the FIFOs respond.
  task automatic cycle(input bit st, input bit em, input bit ur);
    bit pa, pb;
    check_a();
    if (last_a_empty) chk("a_pop_after_empty", a_pop, 0);
    if (last_b_empty) chk("b_pop_after_empty", b_pop, 0);
    a_start = st; a_empty = em; a_under = ur;
    pa = a_pop; pb = b_pop;
    if (pa) a_pops_seen++;
    if (pb) b_pops_seen++;
    model_edge(st, em, ur);
    last_a_empty = em;
    last_b_empty = b_empty;
    @(posedge clk);
    #1;
    if (pa) begin
      a_dout = mem_a[rp_a % A_DEPTH];
      rp_a++;
    end else a_dout = '0;
    b_dq1 = b_dq0;
    if (pb) begin
      b_dq0 = mem_b[rp_b % B_DEPTH];
      rp_b++;
    end else b_dq0 = '0;
    b_dout = b_dq1;
    @(negedge clk);
  endtask

  // Empty modes: 0 never, 1 every third cycle, 2 random with density dens/8.
  task automatic run_a(input int unsigned mode, input int unsigned dens,
                       input int unsigned start_noise, input int unsigned ur_rate,
                       input int unsigned stop_at);
    int unsigned n;
    bit st, em, ur;
    rp_a = 0; a_dout = '0; a_pops_seen = 0;
    cycle(1, 0, 0);
    n = 0;
    while (!m_done && n < 6000) begin
      if (stop_at != 0 && m_pops >= stop_at) return;
      em = (mode == 1) ? (n % 3 == 2) : (mode == 2) ? ($urandom_range(0, 7) < dens) : 1'b0;
      st = (start_noise != 0) && ($urandom_range(1, start_noise) == 1);
      ur = (ur_rate != 0) && ($urandom_range(1, ur_rate) == 1);
      cycle(st, em, ur);
      n++;
    end
    if (!m_done) begin
      total++; bad++;
      $display("FAIL a_pass_timeout: actual=not_done required=done");
    end
  endtask

  task automatic run_b(input int unsigned ur_at, input int unsigned req_cnt,
                       input int unsigned req_fidx, input bit req_mis);
    int unsigned n;
    rp_b = 0; b_dq0 = '0; b_dq1 = '0; b_dout = '0; b_pops_seen = 0;
    b_start = 1;
    cycle(0, 0, 0);
    b_start = 0;
    n = 0;
    while (!b_done && n < 12000) begin
      b_empty = ($urandom_range(0, 3) == 0);
      b_under = (n == ur_at);
      cycle(0, 0, 0);
      n++;
    end
    b_empty = 0; b_under = 0;
    chk("b_done", b_done, 1);
    chk("b_busy", b_busy, 0);
    chk("b_pops", b_pops_seen, B_DEPTH);
    chk("b_error_count", b_cnt, req_cnt);
    chk("b_fail_index", b_fidx, req_fidx);
    chk("b_mismatch", b_mis, req_mis);
    cycle(0, 0, 0);
  endtask

  task automatic fill_mems();
    for (int unsigned i = 0; i < A_DEPTH; i++) mem_a[i] = 18'(pat(i, 18));
    for (int unsigned i = 0; i < B_DEPTH; i++) mem_b[i] = 9'(pat(i, 9));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    a_flush = 1; b_flush = 1;
    a_start = 0; a_empty = 0; a_under = 0; a_dout = '0;
    b_start = 0; b_empty = 0; b_under = 0; b_dout = '0;
    b_dq0 = '0; b_dq1 = '0; rp_a = 0; rp_b = 0;
    a_pops_seen = 0; b_pops_seen = 0; last_a_empty = 0; last_b_empty = 0;
    fill_mems();
    model_reset();
    repeat (3) @(negedge clk);
    a_flush = 0; b_flush = 0;

    // reset state
    chk("reset_pop", a_pop, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    chk("reset_error_count", a_cnt, 0);
    chk("reset_b_pop", b_pop, 0);
    chk("reset_b_fail_index", b_fidx, 0);

    // pattern pins
    chk("pin_word3", pat(3, 18), 'h15003);
    chk("pin_word5", pat(5, 18), 'h15005);
    chk("pin_word7ff_w9", pat('h7FF, 9), 'h1FF);
    chk("pin_mem_a3", mem_a[3], 'h15003);
    chk("pin_mem_b7ff", mem_b['h7FF], 'h1FF);

    // clean pass
    run_a(0, 0, 0, 0, 0);
    chk("p1_done", a_done, 1);
    chk("p1_error_count", a_cnt, 0);
    chk("p1_mismatch", a_mis, 0);
    chk("p1_pops", a_pops_seen, A_DEPTH);
    repeat (2) cycle(0, 0, 0);

    // single corrupted word at index 5
    mem_a[5] = 18'h15004;
    run_a(0, 0, 0, 0, 0);
    chk("p2_done", a_done, 1);
    chk("p2_error_count", a_cnt, 1);
    chk("p2_fail_index", a_fidx, 5);
    chk("p2_mismatch", a_mis, 1);
    chk("p2_pops", a_pops_seen, A_DEPTH);
    fill_mems();
    repeat (2) cycle(0, 0, 0);

    // Empty high every third cycle
    run_a(1, 0, 0, 0, 0);
    chk("p3_done", a_done, 1);
    chk("p3_error_count", a_cnt, 0);
    chk("p3_pops", a_pops_seen, A_DEPTH);
    repeat (2) cycle(0, 0, 0);

    // flush mid-pass at index 300 with an error already counted
    mem_a[10] = mem_a[10] ^ 18'h00001;
    run_a(0, 0, 0, 0, 300);
    chk("p4_pre_flush_count", a_cnt, 1);
    a_flush = 1;
    #1;
    chk("p4_flush_pop", a_pop, 0);
    chk("p4_flush_busy", a_busy, 0);
    chk("p4_flush_error_count", a_cnt, 0);
    chk("p4_flush_mismatch", a_mis, 0);
    chk("p4_flush_fail_index", a_fidx, 0);
    model_reset();
    #1;
    a_flush = 0;
    rp_a = 0; a_dout = '0; last_a_empty = 0;
    fill_mems();
    repeat (2) cycle(0, 0, 0);
    run_a(0, 0, 0, 0, 0);
    chk("p4_rerun_done", a_done, 1);
    chk("p4_rerun_error_count", a_cnt, 0);
    chk("p4_rerun_pops", a_pops_seen, A_DEPTH);
    repeat (2) cycle(0, 0, 0);

    // randomized passes: random stalls, corruption, stray Start and underruns
    for (int p = 0; p < 3; p++) begin
      int unsigned k;
      fill_mems();
      k = $urandom_range(0, 4);
      for (int unsigned c = 0; c < k; c++) begin
        int unsigned at;
        at = $urandom_range(0, A_DEPTH - 1);
        mem_a[at] = mem_a[at] ^ 18'($urandom_range(1, 262143));
      end
      run_a(2, $urandom_range(1, 4), 40, 300, 0);
      chk("pr_pops", a_pops_seen, A_DEPTH);
      repeat (3) cycle(0, 0, 0);
    end
    fill_mems();

    // 9-bit, 2048-word, latency-2 configuration
    run_b(32'hFFFF_FFFF, 0, 0, 0);
    run_b(500, 0, 0, 1);
    mem_b['h7FF] = 9'h0FF;
    run_b(32'hFFFF_FFFF, 1, 'h7FF, 1);
    fill_mems();
    for (int unsigned i = 'h7EB; i < B_DEPTH; i++) mem_b[i] = mem_b[i] ^ 9'h100;
    run_b(32'hFFFF_FFFF, 15, 'h7EB, 1);
    fill_mems();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
